// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a one-entry skid
// buffer so in_ready is registered, plus flush that restores the bubble value.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             emit;

    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // State register; handshake flags are precomputed from the next state so
    // neither output has a combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Next-state and storage update; flush overrides any handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg at WIDTH 32, 1 and 64.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    logic        a_flush = 1'b0;
    logic        a_in_valid = 1'b0;
    logic [0:0]  a_in_data = '0;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [0:0]  a_out_data;
    logic        a_out_ready = 1'b0;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic [63:0] b_in_data = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [63:0] b_out_data;
    logic        b_out_ready = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    pipe_stage_reg #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready)
    );

    pipe_stage_reg #(.WIDTH(64), .BUBBLE(64'h13)) dut_w64 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string name, input logic ov, input logic [31:0] od,
                               input logic ir);
        vectors++;
        if (out_valid !== ov || out_data !== od || in_ready !== ir) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%08h ready=%0b, expected valid=%0b data=%08h ready=%0b",
                     name, out_valid, out_data, in_ready, ov, od, ir);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        expect_main("reset_state", 1'b0, 32'h0, 1'b1);
        step();
        expect_main("reset_nothing_emitted", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
        step();
        expect_main("stream_1", 1'b1, 32'h1, 1'b1);
        in_data = 32'h2;
        step();
        expect_main("stream_2", 1'b1, 32'h2, 1'b1);
        in_data = 32'h3;
        step();
        expect_main("stream_3", 1'b1, 32'h3, 1'b1);
        in_valid = 1'b0;
        step();
        expect_main("stream_drain", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        expect_main("skid_a_in_main", 1'b1, 32'hA, 1'b1);
        in_data = 32'hB;
        step();
        expect_main("skid_full", 1'b1, 32'hA, 1'b0);
        in_data = 32'hC;
        step();
        expect_main("skid_hold_c_blocked", 1'b1, 32'hA, 1'b0);
        out_ready = 1'b1;
        step();
        expect_main("skid_emit_b", 1'b1, 32'hB, 1'b1);
        step();
        expect_main("skid_emit_c", 1'b1, 32'hC, 1'b1);
        in_valid = 1'b0;
        step();
        expect_main("skid_drained", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10;
        step();
        in_data = 32'h11;
        step();
        expect_main("flush_prefull", 1'b1, 32'h10, 1'b0);
        in_data = 32'h12; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        expect_main("flush_full_cleared", 1'b0, 32'h0, 1'b1);
        step();
        expect_main("flush_no_12_later", 1'b0, 32'h0, 1'b1);
        // flush in ONE with a concurrent accept must drop the new payload
        in_valid = 1'b1; in_data = 32'h20; out_ready = 1'b0;
        step();
        in_data = 32'h21; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        expect_main("flush_one_accept_dropped", 1'b0, 32'h0, 1'b1);
        step();
        expect_main("flush_one_stays_empty", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_accept_emit();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        step();
        expect_main("ae_main_5", 1'b1, 32'h5, 1'b1);
        out_ready = 1'b1; in_data = 32'h6;
        step();
        expect_main("ae_main_6", 1'b1, 32'h6, 1'b1);
        in_valid = 1'b0;
        step();
        expect_main("ae_drain", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_midtransfer();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        step();
        in_data = 32'h78;
        step();
        expect_main("rstmid_full", 1'b1, 32'h77, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        expect_main("rstmid_cleared", 1'b0, 32'h0, 1'b1);
        step();
        expect_main("rstmid_skid_gone", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_sweep();
        logic [0:0]  qa[$];
        logic [63:0] qb[$];
        vectors++;
        if (a_out_data !== 1'b0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w1_idle: got valid=%0b data=%0h, expected valid=0 data=0", a_out_valid, a_out_data);
        end
        vectors++;
        if (b_out_data !== 64'h13 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w64_idle: got valid=%0b data=%0h, expected valid=0 data=13", b_out_valid, b_out_data);
        end
        for (int i = 0; i < 400; i++) begin
            logic drain;
            drain = (i >= 380);
            a_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
            a_in_data   = 1'($urandom_range(0, 1));
            a_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            b_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
            b_in_data   = {32'($urandom), 32'($urandom)};
            b_out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
            // occupancy check against scoreboard depth
            vectors++;
            if (a_out_valid !== (qa.size() != 0) || a_in_ready !== (qa.size() < 2)) begin
                errors++;
                $display("FAIL w1_occupancy: got valid=%0b ready=%0b, expected depth=%0d", a_out_valid, a_in_ready, qa.size());
            end
            vectors++;
            if (b_out_valid !== (qb.size() != 0) || b_in_ready !== (qb.size() < 2)) begin
                errors++;
                $display("FAIL w64_occupancy: got valid=%0b ready=%0b, expected depth=%0d", b_out_valid, b_in_ready, qb.size());
            end
            vectors++;
            if (qa.size() != 0 ? a_out_data !== qa[0] : a_out_data !== 1'b0) begin
                errors++;
                $display("FAIL w1_data: got %0h, expected %0h", a_out_data, qa.size() != 0 ? qa[0] : 1'b0);
            end
            vectors++;
            if (qb.size() != 0 ? b_out_data !== qb[0] : b_out_data !== 64'h13) begin
                errors++;
                $display("FAIL w64_data: got %0h, expected %0h", b_out_data, qb.size() != 0 ? qb[0] : 64'h13);
            end
            if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
            if (qa.size() + ((qa.size() != 0 && !a_out_ready) ? 0 : 0) < 2 && a_in_valid && a_in_ready)
                qa.push_back(a_in_data);
            if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());
            if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
            step();
        end
        vectors++;
        if (qa.size() != 0 || qb.size() != 0 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drained: got w1 valid=%0b w64 valid=%0b, expected both 0 with depths %0d/%0d",
                     a_out_valid, b_out_valid, qa.size(), qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_accept_emit();
        test_reset_midtransfer();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
